load_size_unit: RTL and testbench

Load-side counterpart to the store-size merge logic. It issues one memory read, waits a fixed memory latency, then extracts a byte, halfword or word from the returned data with sign or zero extension. The result feeds the memory data register path and implements lb/lbu/lh/lhu/lw. A small FSM sequences the memory read, so the control unit only needs a start pulse and a done pulse.

---
 rtl/load_size_unit.sv | 151 +++++++++++++++
 tb/tb_load_size_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/load_size_unit.sv
// Load-side size unit: issues one memory read, waits MEM_LATENCY cycles, then
// returns a sign- or zero-extended byte, halfword or word with a done pulse.
module load_size_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic [1:0]  load_size_control,
    input  logic        load_signed,
    input  logic [31:0] address,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_data_in,
    output logic [31:0] load_size_out,
    output logic        load_done,
    output logic        load_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
    localparam logic [3:0] LATENCY      = 4'(MEM_LATENCY);

    state_t      state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic [1:0]  size_q,     size_d;
    logic        signed_q,   signed_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_read_q, mem_read_d;
    logic [31:0] result_q,   result_d;
    logic        done_q,     done_d;
    logic        error_q,    error_d;
    logic        busy_q,     busy_d;

    // Lane selection always uses the low bits of the returned word.
    function automatic logic [31:0] extract(input logic [1:0]  size,
                                            input logic        sgn,
                                            input logic [31:0] data);
        logic [31:0] res;
        case (size)
            SIZE_BYTE: res = {{24{sgn & data[7]}}, data[7:0]};
            SIZE_HALF: res = {{16{sgn & data[15]}}, data[15:0]};
            SIZE_WORD: res = data;
            default:   res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        signed_d   = signed_q;
        mem_addr_d = mem_addr_q;
        mem_read_d = 1'b0;
        result_d   = result_q;
        done_d     = 1'b0;
        error_d    = error_q;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (load_size_control == SIZE_ILLEGAL) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        error_d  = 1'b1;
                        result_d = 32'h0000_0000;
                    end else begin
                        state_d    = S_REQ;
                        mem_addr_d = address;
                        size_d     = load_size_control;
                        signed_d   = load_signed;
                        mem_read_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                cnt_d   = LATENCY;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Data is valid in the cycle the counter reads one.
                if (cnt_q <= 4'd1) begin
                    state_d  = S_DONE;
                    cnt_d    = 4'd0;
                    done_d   = 1'b1;
                    error_d  = 1'b0;
                    result_d = extract(size_q, signed_q, mem_data_in);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            mem_addr_q <= 32'h0000_0000;
            mem_read_q <= 1'b0;
            result_q   <= 32'h0000_0000;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            mem_addr_q <= mem_addr_d;
            mem_read_q <= mem_read_d;
            result_q   <= result_d;
            done_q     <= done_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_read      = mem_read_q;
    assign load_size_out = result_q;
    assign load_done     = done_q;
    assign load_error    = error_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_load_size_unit.sv
// Bench for load_size_unit: two instances (latency 1 and 4) share the inputs,
// each with its own memory responder that presents data only in the valid cycle.
module tb_load_size_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load_start, load_signed;
    logic [1:0]  load_size_control;
    logic [31:0] address;
    logic [31:0] mem_addr_a [2];
    logic [31:0] mem_data_a [2];
    logic [31:0] out_a [2];
    logic        mem_read_a [2];
    logic        done_a [2];
    logic        err_a [2];
    logic        busy_a [2];

    load_size_unit #(.MEM_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .load_start(load_start),
        .load_size_control(load_size_control), .load_signed(load_signed),
        .address(address), .mem_addr(mem_addr_a[0]), .mem_read(mem_read_a[0]),
        .mem_data_in(mem_data_a[0]), .load_size_out(out_a[0]),
        .load_done(done_a[0]), .load_error(err_a[0]), .busy(busy_a[0]));

    load_size_unit #(.MEM_LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset(reset), .load_start(load_start),
        .load_size_control(load_size_control), .load_signed(load_signed),
        .address(address), .mem_addr(mem_addr_a[1]), .mem_read(mem_read_a[1]),
        .mem_data_in(mem_data_a[1]), .load_size_out(out_a[1]),
        .load_done(done_a[1]), .load_error(err_a[1]), .busy(busy_a[1]));

    int          checks = 0;
    int          errors = 0;
    int          lat [2] = '{1, 4};
    int          age [2] = '{-1, -1};
    logic [31:0] next_data = 32'h0;

    // Memory: valid word exactly MEM_LATENCY cycles after the read cycle, noise otherwise.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_read_a[d]) age[d] = 0;
            else if (age[d] >= 0) age[d] = age[d] + 1;
            if (age[d] == lat[d]) begin
                mem_data_a[d] = next_data;
                age[d] = -1;
            end else begin
                mem_data_a[d] = $urandom;
            end
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut L=%0d): got %h expected %h", nm, lat[d], act, exp);
        end
    endtask

    // Reference: value of the selected field, wrapped negative when signed and top bit set.
    function automatic logic [31:0] model(input logic [1:0] sz, input logic sg, input logic [31:0] dt);
        longint v;
        case (sz)
            2'd0: begin v = longint'(dt) % 256;   if (sg && v >= 128)   v = v - 256;   end
            2'd1: begin v = longint'(dt) % 65536; if (sg && v >= 32768) v = v - 65536; end
            2'd2: v = longint'(dt);
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    // One load over a fixed 9-cycle window; poke = cycle of a stray start, rst = cycle of a reset.
    task automatic run_load(input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_v, input logic exp_e,
                            input int poke, input int rst);
        int done_cnt [2], done_cyc [2], rd_cnt [2], rd_cyc [2], exp_done [2];
        logic ill;
        ill = (sz == 2'b11);
        for (int d = 0; d < 2; d++) begin
            done_cnt[d] = 0; done_cyc[d] = 0; rd_cnt[d] = 0; rd_cyc[d] = 0;
            exp_done[d] = ill ? 1 : 2 + lat[d];
        end
        @(negedge clk);
        next_data = data; address = addr; load_size_control = sz; load_signed = sg;
        load_start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mem_read_a[d] === 1'b1) begin
                    rd_cnt[d]++; rd_cyc[d] = c;
                    chk("mem_addr", d, mem_addr_a[d], addr);
                end
                if (done_a[d] === 1'b1) begin
                    done_cnt[d]++; done_cyc[d] = c;
                    chk("result", d, out_a[d], exp_v);
                    chk("error", d, 32'(err_a[d]), 32'(exp_e));
                end
                if (rst == 0)
                    chk("busy", d, 32'(busy_a[d]), 32'(c <= exp_done[d]));
                if (rst > 0 && c == rst + 1) begin
                    chk("rst_out", d, out_a[d], 32'h0);
                    chk("rst_addr", d, mem_addr_a[d], 32'h0);
                    chk("rst_flags", d, {28'h0, mem_read_a[d], done_a[d], err_a[d], busy_a[d]}, 32'h0);
                end
            end
            load_start = (c == poke);
            reset = (c == rst);
            address = $urandom;
            load_size_control = 2'($urandom_range(0, 3));
            load_signed = 1'($urandom_range(0, 1));
        end
        load_start = 1'b0;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("done_count", d, 32'(done_cnt[d]), (rst > 0) ? 32'd0 : 32'd1);
            chk("read_count", d, 32'(rd_cnt[d]), ill ? 32'd0 : 32'd1);
            if (rst == 0) chk("done_cycle", d, 32'(done_cyc[d]), 32'(exp_done[d]));
            if (!ill) chk("read_cycle", d, 32'(rd_cyc[d]), 32'd1);
            chk("hold_out", d, out_a[d], (rst > 0) ? 32'h0 : exp_v);
            chk("hold_err", d, 32'(err_a[d]), (rst > 0) ? 32'd0 : 32'(exp_e));
        end
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_v;
        logic        exp_e;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [1:0]  rsz;
        logic        rsg;
        logic [31:0] rdata;

        vecs[0] = '{2'b00, 1'b1, 32'h0000_0040, 32'h1234_5680, 32'hFFFF_FF80, 1'b0};
        vecs[1] = '{2'b00, 1'b0, 32'h0000_0040, 32'h1234_5680, 32'h0000_0080, 1'b0};
        vecs[2] = '{2'b01, 1'b1, 32'h0000_0044, 32'hABCD_8001, 32'hFFFF_8001, 1'b0};
        vecs[3] = '{2'b01, 1'b0, 32'h0000_0044, 32'hABCD_8001, 32'h0000_8001, 1'b0};
        vecs[4] = '{2'b01, 1'b1, 32'h0000_0048, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0};
        vecs[5] = '{2'b10, 1'b1, 32'h0000_004C, 32'h89AB_CDEF, 32'h89AB_CDEF, 1'b0};
        vecs[6] = '{2'b11, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[7] = '{2'b00, 1'b1, 32'h0000_0050, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b0};
        vecs[8] = '{2'b10, 1'b0, 32'hFFFF_FFFC, 32'h8000_0001, 32'h8000_0001, 1'b0};

        reset = 1'b1; load_start = 1'b0; load_signed = 1'b0;
        load_size_control = 2'b00; address = 32'h0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_out", d, out_a[d], 32'h0);
            chk("reset_addr", d, mem_addr_a[d], 32'h0);
            chk("reset_flags", d, {28'h0, mem_read_a[d], done_a[d], err_a[d], busy_a[d]}, 32'h0);
        end
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_load(vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].data,
                     vecs[i].exp_v, vecs[i].exp_e, 0, 0);

        // Stray start during WAIT must be ignored.
        run_load(2'b01, 1'b1, 32'h0000_0200, 32'h1111_F00D, 32'hFFFF_F00D, 1'b0, 2, 0);
        // Reset during WAIT: no done, everything cleared.
        run_load(2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_BABE, 32'h0, 1'b0, 0, 2);
        // Fresh load after the aborted one.
        run_load(2'b00, 1'b0, 32'h0000_0304, 32'h0000_00A5, 32'h0000_00A5, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            rsz = 2'($urandom_range(0, 3));
            rsg = 1'($urandom_range(0, 1));
            rdata = $urandom;
            run_load(rsz, rsg, $urandom, rdata, model(rsz, rsg, rdata), rsz == 2'b11, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
